// File: rtl/fft_pkg.sv
// Shared constants, bit-reverse helper and read FSM state type for the 16-point FFT front end.
package fft_pkg;

  localparam int unsigned DW     = 32;
  localparam int unsigned N      = 16;
  localparam int unsigned LOG2N  = 4;
  localparam logic [DW-1:0] TW_ONE = 32'h0001_0000;

  typedef enum logic [0:0] {
    StIdle,
    StEmit
  } rd_state_e;

  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] idx);
    return {idx[0], idx[1], idx[2], idx[3]};
  endfunction

endpackage

// File: rtl/fft16_frame_bank.sv
// One 16-entry complex frame store: single write port, paired read port at 2k and 2k+1.
module fft16_frame_bank
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LOG2N-1:0]  wr_addr,
  input  logic [2*DW-1:0]   wr_data,
  input  logic [LOG2N-2:0]  rd_pair,
  output logic [2*DW-1:0]   rd_a,
  output logic [2*DW-1:0]   rd_b
);

  logic [2*DW-1:0] mem [N];

  // Contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_a = mem[{rd_pair, 1'b0}];
  assign rd_b = mem[{rd_pair, 1'b1}];

endmodule

// File: rtl/fft16_input_reorder.sv
// Bit-reversing ping-pong input stage: collects 16 natural-order samples per bank and emits
// 8 butterfly pairs per frame with the stage-1 twiddle.
module fft16_input_reorder
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a_real,
  output logic [DW-1:0] a_imag,
  output logic [DW-1:0] b_real,
  output logic [DW-1:0] b_imag,
  output logic [DW-1:0] rotation_factor_real,
  output logic [DW-1:0] rotation_factor_imag,
  output logic [2:0]    pair_idx,
  output logic          frame_last
);

  localparam int unsigned PW = LOG2N - 1;
  localparam logic [LOG2N-1:0] LastSample = LOG2N'(N - 1);
  localparam logic [PW-1:0]    LastPair   = '1;

  logic             wr_bank_q;
  logic [LOG2N-1:0] wr_cnt_q;
  logic [1:0]       full_q, full_d;
  logic             rd_bank_q, rd_bank_d;
  rd_state_e        state_q, state_d;

  logic             accept;
  logic             load;
  logic             load_bank;
  logic [PW-1:0]    load_k;
  logic             clr_full;
  logic [2*DW-1:0]  bank_a [2];
  logic [2*DW-1:0]  bank_b [2];

  assign in_ready = ~full_q[wr_bank_q];
  assign accept   = in_valid & in_ready;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft16_frame_bank u_bank (
      .clk     (clk),
      .wr_en   (accept && (wr_bank_q == 1'(g))),
      .wr_addr (bitrev4(wr_cnt_q)),
      .wr_data ({in_real, in_imag}),
      .rd_pair (load_k),
      .rd_a    (bank_a[g]),
      .rd_b    (bank_b[g])
    );
  end

  // Writer only fills a bank whose flag is clear and reader only clears a set flag, so the
  // two updates never target the same bit.
  always_comb begin
    full_d = full_q;
    if (accept && (wr_cnt_q == LastSample)) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (clr_full) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      full_q    <= '0;
    end else begin
      full_q <= full_d;
      if (accept) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (wr_cnt_q == LastSample) begin
          wr_bank_q <= ~wr_bank_q;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    load      = 1'b0;
    load_bank = rd_bank_q;
    load_k    = '0;
    clr_full  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          load    = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (pair_idx != LastPair) begin
            load   = 1'b1;
            load_k = pair_idx + 1'b1;
          end else begin
            clr_full  = 1'b1;
            rd_bank_d = ~rd_bank_q;
            if (full_q[~rd_bank_q]) begin
              load      = 1'b1;
              load_bank = ~rd_bank_q;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_bank_q  <= 1'b0;
      out_valid  <= 1'b0;
      a_real     <= '0;
      a_imag     <= '0;
      b_real     <= '0;
      b_imag     <= '0;
      pair_idx   <= '0;
      frame_last <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      if (load) begin
        out_valid        <= 1'b1;
        {a_real, a_imag} <= bank_a[load_bank];
        {b_real, b_imag} <= bank_b[load_bank];
        pair_idx         <= load_k;
        frame_last       <= (load_k == LastPair);
      end else if (state_d == StIdle) begin
        out_valid  <= 1'b0;
        a_real     <= '0;
        a_imag     <= '0;
        b_real     <= '0;
        b_imag     <= '0;
        pair_idx   <= '0;
        frame_last <= 1'b0;
      end
    end
  end

  assign rotation_factor_real = out_valid ? TW_ONE : '0;
  assign rotation_factor_imag = '0;

endmodule
